// File: rtl/session_pkg.sv
// Shared types, default parameters and width helpers for the session sequencer.
//   state_t        : FSM state encoding
//   *_DEF          : parameter defaults used by the top and the interface
//   SESS_W/FAIL_W/TMR_W : counter/timer widths derived from the defaults
package session_pkg;

    localparam int unsigned CODE_W_DEF      = 4;
    localparam int unsigned SESSIONS_DEF    = 4;
    localparam int unsigned MAX_FAILS_DEF   = 3;
    localparam int unsigned TIMEOUT_CYC_DEF = 1000;

    // Width needed to count 0..n-1, never less than one bit.
    function automatic int unsigned clog2_min1(input int unsigned n);
        if (n <= 1) begin
            return 1;
        end
        return $clog2(n);
    endfunction

    localparam int unsigned SESS_W = $clog2(SESSIONS_DEF + 1);
    localparam int unsigned FAIL_W = $clog2(MAX_FAILS_DEF + 1);
    localparam int unsigned TMR_W  = clog2_min1(TIMEOUT_CYC_DEF);

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_LOAD    = 3'd1,
        ST_WAIT    = 3'd2,
        ST_CHECK   = 3'd3,
        ST_DONE    = 3'd4,
        ST_LOCKOUT = 3'd5
    } state_t;

endpackage

// File: rtl/session_if.sv
// Handshake/status bundle between a user-side driver and the session sequencer.
//   master : drives go, target, code_in, code_valid; observes status/pulses
//   slave  : the sequencer side (inverse directions)
interface session_if
    import session_pkg::*;
#(
    parameter int unsigned CODE_W = CODE_W_DEF,
    parameter int unsigned IDX_W  = SESS_W
);
    logic              go;
    logic [CODE_W-1:0] target;
    logic [CODE_W-1:0] code_in;
    logic              code_valid;
    logic              session_active;
    logic [IDX_W-1:0]  session_idx;
    logic              pass_pulse;
    logic              fail_pulse;
    logic              timeout_err;
    logic              done;
    logic              locked;

    modport master (
        output go, target, code_in, code_valid,
        input  session_active, session_idx, pass_pulse, fail_pulse,
               timeout_err, done, locked
    );

    modport slave (
        input  go, target, code_in, code_valid,
        output session_active, session_idx, pass_pulse, fail_pulse,
               timeout_err, done, locked
    );
endinterface

// File: rtl/session_counter.sv
// Saturating up-counter with synchronous clear and an at-max flag.
//   clk, rst   : clock, async active-high reset
//   i_clr      : synchronous clear (wins over increment)
//   i_inc      : increment request, ignored once the count reaches MAX
//   o_count    : current count
//   o_at_max   : count equals MAX
module session_counter #(
    parameter int unsigned W   = 3,
    parameter int unsigned MAX = 4
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_clr,
    input  logic         i_inc,
    output logic [W-1:0] o_count,
    output logic         o_at_max
);

    logic [W-1:0] r_count;
    logic         w_at_max;

    assign w_at_max = (r_count == W'(MAX));

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_count <= '0;
        end else if (i_clr) begin
            r_count <= '0;
        end else if (i_inc && !w_at_max) begin
            r_count <= r_count + W'(1);
        end
    end

    assign o_count  = r_count;
    assign o_at_max = w_at_max;

endmodule

// File: rtl/session_sequencer.sv
// Multi-session code-entry sequencer: each session latches a target, waits
// for a user code (with timeout), and scores it. SESSIONS passes complete the
// run; MAX_FAILS cumulative failures lock the block until reset.
//   clk   : system clock, rising edge
//   start : async active-high reset
//   bus   : session_if slave (go/target/code in; status and pulses out)
module session_sequencer
    import session_pkg::*;
#(
    parameter int unsigned CODE_W      = CODE_W_DEF,
    parameter int unsigned SESSIONS    = SESSIONS_DEF,
    parameter int unsigned MAX_FAILS   = MAX_FAILS_DEF,
    parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
    input  logic     clk,
    input  logic     start,
    session_if.slave bus
);

    localparam int unsigned L_SESS_W = $clog2(SESSIONS + 1);
    localparam int unsigned L_FAIL_W = $clog2(MAX_FAILS + 1);
    localparam int unsigned L_TMR_W  = clog2_min1(TIMEOUT_CYC);

    state_t              r_state;
    logic [L_TMR_W-1:0]  r_timer;
    logic [CODE_W-1:0]   r_target;
    logic [CODE_W-1:0]   r_code;
    logic                r_tmo_pulse;

    logic [L_SESS_W-1:0] w_pass_cnt;
    logic [L_FAIL_W-1:0] w_fail_cnt;
    logic                w_pass_at_max;
    logic                w_fail_at_max;
    logic                w_match;
    logic                w_tmr_expired;
    logic                w_timeout;
    logic                w_pass_last;
    logic                w_fail_last;
    logic                w_clr;
    logic                w_pass_inc;
    logic                w_fail_inc;

    assign w_match       = (r_code == r_target);
    assign w_tmr_expired = (r_timer == L_TMR_W'(TIMEOUT_CYC - 1));
    // A code strobe in the expiry cycle takes priority over the timeout.
    assign w_timeout     = (r_state == ST_WAIT) && !bus.code_valid && w_tmr_expired;
    // The counters update on the same edge the FSM leaves CHECK/WAIT, so the
    // exit decision looks one step ahead of the registered count.
    assign w_pass_last   = (w_pass_cnt == L_SESS_W'(SESSIONS - 1));
    assign w_fail_last   = (w_fail_cnt == L_FAIL_W'(MAX_FAILS - 1));
    assign w_clr         = bus.go && ((r_state == ST_IDLE) || (r_state == ST_DONE));
    assign w_pass_inc    = (r_state == ST_CHECK) && w_match && !w_pass_at_max;
    assign w_fail_inc    = (((r_state == ST_CHECK) && !w_match) || w_timeout) && !w_fail_at_max;

    session_counter #(
        .W   (L_SESS_W),
        .MAX (SESSIONS)
    ) u_pass_cnt (
        .clk      (clk),
        .rst      (start),
        .i_clr    (w_clr),
        .i_inc    (w_pass_inc),
        .o_count  (w_pass_cnt),
        .o_at_max (w_pass_at_max)
    );

    session_counter #(
        .W   (L_FAIL_W),
        .MAX (MAX_FAILS)
    ) u_fail_cnt (
        .clk      (clk),
        .rst      (start),
        .i_clr    (w_clr),
        .i_inc    (w_fail_inc),
        .o_count  (w_fail_cnt),
        .o_at_max (w_fail_at_max)
    );

    // Session FSM, wait timer and code/target capture.
    always_ff @(posedge clk or posedge start) begin
        if (start) begin
            r_state     <= ST_IDLE;
            r_timer     <= '0;
            r_target    <= '0;
            r_code      <= '0;
            r_tmo_pulse <= 1'b0;
        end else begin
            r_tmo_pulse <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    if (bus.go) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOAD: begin
                    r_target <= bus.target;
                    r_timer  <= '0;
                    r_state  <= ST_WAIT;
                end
                ST_WAIT: begin
                    r_timer <= r_timer + L_TMR_W'(1);
                    if (bus.code_valid) begin
                        r_code  <= bus.code_in;
                        r_state <= ST_CHECK;
                    end else if (w_tmr_expired) begin
                        r_tmo_pulse <= 1'b1;
                        r_state     <= w_fail_last ? ST_LOCKOUT : ST_LOAD;
                    end
                end
                ST_CHECK: begin
                    if (w_match) begin
                        r_state <= w_pass_last ? ST_DONE : ST_LOAD;
                    end else begin
                        r_state <= w_fail_last ? ST_LOCKOUT : ST_LOAD;
                    end
                end
                ST_DONE: begin
                    if (bus.go) begin
                        r_state <= ST_LOAD;
                    end
                end
                ST_LOCKOUT: begin
                    r_state <= ST_LOCKOUT;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    // Outputs decode only registered state, so reset clears them at once.
    assign bus.session_active = (r_state == ST_LOAD) || (r_state == ST_WAIT) ||
                                (r_state == ST_CHECK);
    assign bus.session_idx    = w_pass_cnt;
    assign bus.pass_pulse     = (r_state == ST_CHECK) && w_match;
    assign bus.fail_pulse     = ((r_state == ST_CHECK) && !w_match) || r_tmo_pulse;
    assign bus.timeout_err    = r_tmo_pulse;
    assign bus.done           = (r_state == ST_DONE);
    assign bus.locked         = (r_state == ST_LOCKOUT);

endmodule

// File: tb/tb_session_sequencer.sv
// Scoreboard bench: stimulus pushes expected pulse events, a negedge monitor
// pops and compares each pulse the DUT presents; status is checked inline.
module tb_session_sequencer;

    logic clk;
    logic start;

    int n_checks = 0;
    int n_errors = 0;

    typedef struct {
        logic       pass;
        logic       fail;
        logic       tmo;
        logic [2:0] idx;
    } ev_t;

    ev_t exp_q[$];

    session_if #(.CODE_W(4), .IDX_W(3)) bus ();

    session_sequencer #(
        .CODE_W      (4),
        .SESSIONS    (4),
        .MAX_FAILS   (3),
        .TIMEOUT_CYC (8)
    ) dut (
        .clk   (clk),
        .start (start),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input int act, input int exp);
        n_checks++;
        if (act != exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic push_ev(input logic pass, input logic fail, input logic tmo,
                           input logic [2:0] idx);
        ev_t e;
        e.pass = pass;
        e.fail = fail;
        e.tmo  = tmo;
        e.idx  = idx;
        exp_q.push_back(e);
    endtask

    task automatic do_go();
        bus.go = 1'b1;
        tick();
        bus.go = 1'b0;
    endtask

    // Enter one code from WAIT; leaves the FSM back in WAIT (or DONE/LOCKOUT).
    task automatic entry(input logic [3:0] code, input logic exp_pass, input logic [2:0] exp_idx);
        push_ev(exp_pass, !exp_pass, 1'b0, exp_idx);
        bus.code_valid = 1'b1;
        bus.code_in    = code;
        tick();
        bus.code_valid = 1'b0;
        tick();
        tick();
    endtask

    task automatic chk_all_zero(input string tag);
        chk({tag, "_active"}, int'(bus.session_active), 0);
        chk({tag, "_idx"},    int'(bus.session_idx),    0);
        chk({tag, "_pass"},   int'(bus.pass_pulse),     0);
        chk({tag, "_fail"},   int'(bus.fail_pulse),     0);
        chk({tag, "_tmo"},    int'(bus.timeout_err),    0);
        chk({tag, "_done"},   int'(bus.done),           0);
        chk({tag, "_locked"}, int'(bus.locked),         0);
    endtask

    // Monitor: every cycle with a pulse must match the next expected event.
    always @(negedge clk) begin
        if (bus.pass_pulse || bus.fail_pulse || bus.timeout_err) begin
            n_checks++;
            if (exp_q.size() == 0) begin
                n_errors++;
                $display("FAIL unexpected_pulse: got pass=%0b fail=%0b tmo=%0b idx=%0d, expected none at %0t",
                         bus.pass_pulse, bus.fail_pulse, bus.timeout_err, bus.session_idx, $time);
            end else begin
                ev_t e;
                e = exp_q.pop_front();
                if (bus.pass_pulse !== e.pass || bus.fail_pulse !== e.fail ||
                    bus.timeout_err !== e.tmo || bus.session_idx !== e.idx) begin
                    n_errors++;
                    $display("FAIL pulse_event: got pass=%0b fail=%0b tmo=%0b idx=%0d, expected pass=%0b fail=%0b tmo=%0b idx=%0d at %0t",
                             bus.pass_pulse, bus.fail_pulse, bus.timeout_err, bus.session_idx,
                             e.pass, e.fail, e.tmo, e.idx, $time);
                end
            end
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        start          = 1'b0;
        bus.go         = 1'b0;
        bus.target     = 4'h0;
        bus.code_in    = 4'h0;
        bus.code_valid = 1'b0;
        #1 start = 1'b1;
        #2;
        chk_all_zero("reset");
        tick();
        tick();
        start = 1'b0;

        // code_valid in IDLE is ignored
        bus.target     = 4'hA;
        bus.code_valid = 1'b1;
        bus.code_in    = 4'hA;
        tick();
        bus.code_valid = 1'b0;
        tick();
        chk("idle_active", int'(bus.session_active), 0);
        chk("idle_idx",    int'(bus.session_idx),    0);

        // Run 1: one miss, then four passes to DONE
        do_go();
        chk("run1_load_active", int'(bus.session_active), 1);
        tick();
        entry(4'h3, 1'b0, 3'd0);
        chk("run1_idx_after_fail", int'(bus.session_idx), 0);
        entry(4'hA, 1'b1, 3'd0);
        chk("run1_idx1", int'(bus.session_idx), 1);
        entry(4'hA, 1'b1, 3'd1);
        chk("run1_idx2", int'(bus.session_idx), 2);
        entry(4'hA, 1'b1, 3'd2);
        chk("run1_idx3", int'(bus.session_idx), 3);
        entry(4'hA, 1'b1, 3'd3);
        chk("run1_done",   int'(bus.done),           1);
        chk("run1_idx4",   int'(bus.session_idx),    4);
        chk("run1_active", int'(bus.session_active), 0);

        // Run 2 from DONE: earlier fail must not carry over; then lockout
        bus.target = 4'h5;
        do_go();
        chk("run2_done_drop", int'(bus.done),        0);
        chk("run2_idx0",      int'(bus.session_idx), 0);
        tick();
        entry(4'h6, 1'b0, 3'd0);
        entry(4'h6, 1'b0, 3'd0);
        chk("run2_not_locked", int'(bus.locked), 0);
        entry(4'h5, 1'b1, 3'd0);
        chk("run2_idx1", int'(bus.session_idx), 1);
        entry(4'h6, 1'b0, 3'd1);
        chk("lock_locked", int'(bus.locked),         1);
        chk("lock_active", int'(bus.session_active), 0);

        // go and code_valid in LOCKOUT are ignored
        do_go();
        bus.code_valid = 1'b1;
        tick();
        bus.code_valid = 1'b0;
        tick();
        chk("lock_go_ignored", int'(bus.locked),         1);
        chk("lock_go_active",  int'(bus.session_active), 0);

        start = 1'b1;
        #1;
        chk("lock_reset_locked", int'(bus.locked),      0);
        chk("lock_reset_idx",    int'(bus.session_idx), 0);
        tick();
        start = 1'b0;

        // Timeout: pulse 8 cycles after WAIT entry, back to LOAD
        do_go();
        tick();
        push_ev(1'b0, 1'b1, 1'b1, 3'd0);
        repeat (7) tick();
        chk("tmo_early_fail", int'(bus.fail_pulse), 0);
        tick();
        chk("tmo_fail",   int'(bus.fail_pulse),     1);
        chk("tmo_err",    int'(bus.timeout_err),    1);
        chk("tmo_active", int'(bus.session_active), 1);
        tick();

        // Code on the 8th WAIT cycle beats the timeout
        repeat (7) tick();
        push_ev(1'b1, 1'b0, 1'b0, 3'd0);
        bus.code_valid = 1'b1;
        bus.code_in    = 4'h5;
        tick();
        bus.code_valid = 1'b0;
        chk("late_pass",   int'(bus.pass_pulse),  1);
        chk("late_no_tmo", int'(bus.timeout_err), 0);
        tick();
        tick();
        chk("late_idx1", int'(bus.session_idx), 1);

        // Reset between edges mid-WAIT clears outputs immediately
        #2 start = 1'b1;
        #1;
        chk_all_zero("midreset");
        @(posedge clk);
        #1;
        // First go right after release must be taken
        bus.target = 4'h9;
        bus.go     = 1'b1;
        start      = 1'b0;
        tick();
        bus.go = 1'b0;
        chk("release_go_active", int'(bus.session_active), 1);
        chk("release_idx",       int'(bus.session_idx),    0);
        tick();
        entry(4'h9, 1'b1, 3'd0);
        chk("release_idx1", int'(bus.session_idx), 1);
        tick();
        tick();

        chk("scoreboard_empty", exp_q.size(), 0);
        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/session_sequencer.md
SESSION_SEQUENCER -- requirements
Module: session_sequencer

Interface
REQ-001 Parameter CODE_W, default 4, width of entry code and target.
REQ-002 Parameter SESSIONS, default 4, successful sessions required for completion.
REQ-003 Parameter MAX_FAILS, default 3, failed attempts before lockout.
REQ-004 Parameter TIMEOUT_CYC, default 1000, cycles allowed in WAIT before a timeout failure.
REQ-005 clk  in  1  single system clock; all state changes on rising edge.
REQ-006 start  in  1  reset, asynchronous, active-high.
REQ-007 go  in  1  request to begin a run; sampled in IDLE and DONE only.
REQ-008 target  in  CODE_W  expected code; latched in LOAD.
REQ-009 code_in  in  CODE_W  user entry; valid when code_valid=1.
REQ-010 code_valid  in  1  one-cycle strobe qualifying code_in.
REQ-011 session_active  out  1  high in LOAD, WAIT, CHECK.
REQ-012 session_idx  out  SESS_W  completed-session count (0..SESSIONS).
REQ-013 pass_pulse  out  1  one-cycle pulse on a matching entry.
REQ-014 fail_pulse  out  1  one-cycle pulse on mismatch or timeout.
REQ-015 timeout_err  out  1  one-cycle pulse coincident with a timeout fail_pulse.
REQ-016 done  out  1  held high in DONE.
REQ-017 locked  out  1  held high in LOCKOUT.

Function
REQ-018 FSM states SHALL be IDLE, LOAD, WAIT, CHECK, DONE, LOCKOUT.
REQ-019 IDLE: go=1 -> LOAD next cycle; pass and fail counters cleared.
REQ-020 LOAD: target latched into target_q, timer cleared -> WAIT unconditionally (1 cycle).
REQ-021 WAIT: timer increments each cycle; code_valid=1 -> code_q<=code_in, -> CHECK.
REQ-022 WAIT: timer==TIMEOUT_CYC-1 with code_valid=0 -> fail_pulse and timeout_err for one cycle, fail counter +1, -> LOAD or LOCKOUT per REQ-025.
REQ-023 code_valid and timeout in the same cycle: code wins, no timeout_err.
REQ-024 CHECK (1 cycle, pulses decoded from state; latency code_valid -> pulse = 1 cycle): code_q==target_q -> pass_pulse, pass counter +1; reaching SESSIONS -> DONE, else LOAD.
REQ-025 Mismatch -> fail_pulse, fail counter +1; reaching MAX_FAILS -> LOCKOUT, else LOAD (same session_idx retried).
REQ-026 Fail counter SHALL NOT clear on pass; cumulative per run.
REQ-027 go while session_active=1 or in LOCKOUT SHALL be ignored.
REQ-028 code_valid outside WAIT SHALL be ignored.
REQ-029 DONE: done=1, session_idx=SESSIONS held; go=1 -> LOAD with both counters cleared.
REQ-030 LOCKOUT: locked=1 held; exit only via start.
REQ-031 Counters saturate; never wrap past SESSIONS or MAX_FAILS.

Reset
REQ-032 start=1 SHALL force IDLE, counters, timer, target_q, code_q to 0 and all outputs to 0 immediately, independent of clk.
REQ-033 Reset mid-run SHALL discard the run; no pulse SHALL be emitted on reset release.
REQ-034 First go SHALL be honoured on the first clk edge after start deasserts.

Structure
REQ-035 Package session_pkg SHALL hold the state enum, SESS_W=$clog2(SESSIONS+1), FAIL_W, TMR_W and parameter defaults.
REQ-036 Sub-module session_counter (sync clear, increment, saturate at MAX, at_max flag) SHALL be instantiated twice: pass and fail counters.
REQ-037 Timer and FSM SHALL reside in session_sequencer; all outputs registered or decoded from state only.

Verification
REQ-038 go, target=4'hA, four entries of 4'hA -> four pass_pulses, session_idx 1,2,3,4, done=1 after 4th CHECK.
REQ-039 target=4'h5, three entries of 4'h6 -> three fail_pulses, locked=1; subsequent go ignored, locked cleared only by start.
REQ-040 TIMEOUT_CYC=8, no code_valid -> fail_pulse and timeout_err 8 cycles after WAIT entry, return to LOAD.
REQ-041 TIMEOUT_CYC=8, code_valid=1 with matching code on 8th WAIT cycle -> pass_pulse, no timeout_err.
REQ-042 start asserted mid-WAIT between clk edges -> all outputs 0 immediately, IDLE; no pulse after release.
REQ-043 In DONE, go=1 -> done drops, session_idx=0, new run begins; one earlier fail does not carry over.
